dafx_amplitude_monitor: RTL

Sits between the audio sample path (ADC capture, mixer output to DAC) and the DAFX AXI register slave. Tracks the running signed min/max amplitude of the ADC and DAC stereo streams and the last mixer output sample. Raises sticky clip interrupts when either stream reaches a threshold. Consumes the slave's clear commands and produces the sr_cir_*, sr_mix_out_* status words and irq lines.

---
 rtl/dafx_amplitude_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dafx_amplitude_monitor.sv
// Running signed min/max amplitude tracking, last mixer sample and sticky clip
// interrupts for the DAFX ADC and DAC stereo sample streams.
module dafx_amplitude_monitor #(
    parameter int AUDIO_WIDTH_C    = 24,
    parameter int CLIP_THRESHOLD_C = 8000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adc_valid,
    input  logic [AUDIO_WIDTH_C-1:0] adc_left,
    input  logic [AUDIO_WIDTH_C-1:0] adc_right,
    input  logic                     dac_valid,
    input  logic [AUDIO_WIDTH_C-1:0] dac_left,
    input  logic [AUDIO_WIDTH_C-1:0] dac_right,
    input  logic                     cmd_clear_adc_amplitude,
    input  logic                     cmd_clear_irq_0,
    input  logic                     cmd_clear_irq_1,
    output logic [AUDIO_WIDTH_C-1:0] sr_cir_min_adc_amplitude,
    output logic [AUDIO_WIDTH_C-1:0] sr_cir_max_adc_amplitude,
    output logic [AUDIO_WIDTH_C-1:0] sr_cir_min_dac_amplitude,
    output logic [AUDIO_WIDTH_C-1:0] sr_cir_max_dac_amplitude,
    output logic [AUDIO_WIDTH_C-1:0] sr_mix_out_left,
    output logic [AUDIO_WIDTH_C-1:0] sr_mix_out_right,
    output logic                     irq_0,
    output logic                     irq_1
);

    localparam int W = AUDIO_WIDTH_C;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] CLIP_THR = W'(CLIP_THRESHOLD_C);

    // Magnitude of a signed sample; the most negative code saturates to MAX_POS.
    function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
        logic [W-1:0] r;
        if (x == MAX_NEG) begin
            r = MAX_POS;
        end else if (x[W-1]) begin
            r = (~x) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic signed_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

    logic [W-1:0] adc_pair_min_s, adc_pair_max_s, dac_pair_min_s, dac_pair_max_s;
    logic         adc_clip_s, dac_clip_s;

    logic         adc_s1_valid_r, dac_s1_valid_r;
    logic [W-1:0] adc_pair_min_r, adc_pair_max_r, dac_pair_min_r, dac_pair_max_r;
    logic         adc_clip_r, dac_clip_r;

    logic [W-1:0] adc_min_r, adc_max_r, dac_min_r, dac_max_r;
    logic [W-1:0] mix_left_r, mix_right_r;
    logic         irq_0_r, irq_1_r;

    // Per-pair signed min/max and clip detection of the incoming samples.
    always_comb begin
        adc_pair_min_s = signed_lt(adc_left, adc_right) ? adc_left : adc_right;
        adc_pair_max_s = signed_lt(adc_left, adc_right) ? adc_right : adc_left;
        dac_pair_min_s = signed_lt(dac_left, dac_right) ? dac_left : dac_right;
        dac_pair_max_s = signed_lt(dac_left, dac_right) ? dac_right : dac_left;
        adc_clip_s = (sat_abs(adc_left) >= CLIP_THR) || (sat_abs(adc_right) >= CLIP_THR);
        dac_clip_s = (sat_abs(dac_left) >= CLIP_THR) || (sat_abs(dac_right) >= CLIP_THR);
    end

    // Stage 1: capture pair extremes and clip flag; mixer output loads here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_s1_valid_r <= 1'b0;
            dac_s1_valid_r <= 1'b0;
            adc_pair_min_r <= {W{1'b0}};
            adc_pair_max_r <= {W{1'b0}};
            dac_pair_min_r <= {W{1'b0}};
            dac_pair_max_r <= {W{1'b0}};
            adc_clip_r     <= 1'b0;
            dac_clip_r     <= 1'b0;
            mix_left_r     <= {W{1'b0}};
            mix_right_r    <= {W{1'b0}};
        end else begin
            adc_s1_valid_r <= adc_valid;
            dac_s1_valid_r <= dac_valid;
            if (adc_valid) begin
                adc_pair_min_r <= adc_pair_min_s;
                adc_pair_max_r <= adc_pair_max_s;
                adc_clip_r     <= adc_clip_s;
            end
            if (dac_valid) begin
                dac_pair_min_r <= dac_pair_min_s;
                dac_pair_max_r <= dac_pair_max_s;
                dac_clip_r     <= dac_clip_s;
                mix_left_r     <= dac_left;
                mix_right_r    <= dac_right;
            end
        end
    end

    // Stage 2: commit into trackers; an amplitude clear discards the committing ADC sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_min_r <= MAX_POS;
            adc_max_r <= MAX_NEG;
            dac_min_r <= MAX_POS;
            dac_max_r <= MAX_NEG;
            irq_0_r   <= 1'b0;
            irq_1_r   <= 1'b0;
        end else begin
            if (cmd_clear_adc_amplitude) begin
                adc_min_r <= MAX_POS;
                adc_max_r <= MAX_NEG;
            end else if (adc_s1_valid_r) begin
                if (signed_lt(adc_pair_min_r, adc_min_r)) adc_min_r <= adc_pair_min_r;
                if (signed_lt(adc_max_r, adc_pair_max_r)) adc_max_r <= adc_pair_max_r;
            end
            if (dac_s1_valid_r) begin
                if (signed_lt(dac_pair_min_r, dac_min_r)) dac_min_r <= dac_pair_min_r;
                if (signed_lt(dac_max_r, dac_pair_max_r)) dac_max_r <= dac_pair_max_r;
            end
            // Set has priority over a coincident clear.
            if (adc_s1_valid_r && adc_clip_r && !cmd_clear_adc_amplitude) begin
                irq_0_r <= 1'b1;
            end else if (cmd_clear_irq_0) begin
                irq_0_r <= 1'b0;
            end
            if (dac_s1_valid_r && dac_clip_r) begin
                irq_1_r <= 1'b1;
            end else if (cmd_clear_irq_1) begin
                irq_1_r <= 1'b0;
            end
        end
    end

    assign sr_cir_min_adc_amplitude = adc_min_r;
    assign sr_cir_max_adc_amplitude = adc_max_r;
    assign sr_cir_min_dac_amplitude = dac_min_r;
    assign sr_cir_max_dac_amplitude = dac_max_r;
    assign sr_mix_out_left          = mix_left_r;
    assign sr_mix_out_right         = mix_right_r;
    assign irq_0                    = irq_0_r;
    assign irq_1                    = irq_1_r;

endmodule
